// File: rtl/control_unit.sv
// Multicycle RV32I control FSM: registered state, combinational control outputs.
// Optional CU_ILLEGAL_HALT_EN: unlisted opcodes park the FSM in HALT until reset.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       PCEnable,
  output logic       InstructionRegisterEnable,
  output logic       OLDPCEnable,
  output logic       InstructionOrData,
  output logic [2:0] ImmediateSrc,
  output logic       REGAEnable,
  output logic       REGBEnable,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControlSignal,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic       RegWrite
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_BRANCH, S_JUMP, S_LINK, S_LUI, S_AUIPC, S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_unused_funct7;

  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Immediate forms never subtract; funct7[5] there only selects SRAI.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic is_imm);
    case (f3)
      3'b000:  alu_decode = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_MEMADR;
          OP_BRANCH:          w_next = S_BRANCH;
          OP_JAL, OP_JALR:    w_next = S_JUMP;
          OP_LUI:             w_next = S_LUI;
          OP_AUIPC:           w_next = S_AUIPC;
`ifdef CU_ILLEGAL_HALT_EN
          default:            w_next = S_HALT;
`else
          default:            w_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_ALUWB;
      S_MEMADR:   w_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_JUMP:     w_next = S_LINK;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCEnable                  = 1'b0;
    InstructionRegisterEnable = 1'b0;
    OLDPCEnable               = 1'b0;
    InstructionOrData         = 1'b0;
    ImmediateSrc              = 3'd0;
    REGAEnable                = 1'b0;
    REGBEnable                = 1'b0;
    ALUSrcA                   = 2'd0;
    ALUSrcB                   = 2'd0;
    ALUControlSignal          = ALU_ADD;
    ResultSrc                 = 2'd0;
    MemWrite                  = 1'b0;
    RegWrite                  = 1'b0;
    case (r_state)
      S_FETCH: begin
        InstructionRegisterEnable = 1'b1;
        OLDPCEnable = 1'b1;
        PCEnable    = 1'b1;
        ALUSrcB     = 2'd2;
        ResultSrc   = 2'd2;
      end
      S_DECODE: begin
        REGAEnable = 1'b1;
        REGBEnable = 1'b1;
        // Branch target OLDPC+immB is computed here and parked in ALUOUT.
        if (opcode == OP_BRANCH) begin
          ALUSrcA      = 2'd1;
          ALUSrcB      = 2'd1;
          ImmediateSrc = 3'd2;
        end
      end
      S_EXEC_R: begin
        ALUSrcA          = 2'd2;
        ALUControlSignal = alu_decode(funct3, funct7[5], 1'b0);
      end
      S_EXEC_I: begin
        ALUSrcA          = 2'd2;
        ALUSrcB          = 2'd1;
        ALUControlSignal = alu_decode(funct3, funct7[5], 1'b1);
      end
      S_ALUWB: RegWrite = 1'b1;
      S_MEMADR: begin
        ALUSrcA      = 2'd2;
        ALUSrcB      = 2'd1;
        ImmediateSrc = (opcode == OP_STORE) ? 3'd1 : 3'd0;
      end
      S_MEMREAD: begin
        ALUSrcA           = 2'd2;
        ALUSrcB           = 2'd1;
        InstructionOrData = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'd1;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        ALUSrcA           = 2'd2;
        ALUSrcB           = 2'd1;
        ImmediateSrc      = 3'd1;
        InstructionOrData = 1'b1;
        MemWrite          = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'd2;
        case (funct3)
          3'b000: begin ALUControlSignal = ALU_SUB;  PCEnable = Zero;  end
          3'b001: begin ALUControlSignal = ALU_SUB;  PCEnable = !Zero; end
          3'b100: begin ALUControlSignal = ALU_SLT;  PCEnable = !Zero; end
          3'b101: begin ALUControlSignal = ALU_SLT;  PCEnable = Zero;  end
          3'b110: begin ALUControlSignal = ALU_SLTU; PCEnable = !Zero; end
          3'b111: begin ALUControlSignal = ALU_SLTU; PCEnable = Zero;  end
          default: ;
        endcase
      end
      S_JUMP: begin
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        PCEnable  = 1'b1;
        if (opcode == OP_JAL) begin
          ALUSrcA      = 2'd1;
          ImmediateSrc = 3'd4;
        end else begin
          ALUSrcA      = 2'd2;
        end
      end
      S_LINK: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        RegWrite  = 1'b1;
      end
      S_LUI: begin
        ImmediateSrc = 3'd3;
        ResultSrc    = 2'd3;
        RegWrite     = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA      = 2'd1;
        ALUSrcB      = 2'd1;
        ImmediateSrc = 3'd3;
        ResultSrc    = 2'd2;
        RegWrite     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected control vectors are queued
// at instruction issue and compared at each falling edge.
module tb_control_unit;

  typedef struct packed {
    logic       pc, ir, oldpc, iod;
    logic [2:0] imm;
    logic       rega, regb;
    logic [1:0] srca, srcb;
    logic [3:0] alu;
    logic [1:0] res;
    logic       mw, rw;
  } ctrl_t;

  typedef struct {
    string tag;
    ctrl_t v;
  } exp_t;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_SLT = 4'd8, A_SLTU = 4'd9;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       PCEnable, InstructionRegisterEnable, OLDPCEnable, InstructionOrData;
  logic [2:0] ImmediateSrc;
  logic       REGAEnable, REGBEnable;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [3:0] ALUControlSignal;
  logic [1:0] ResultSrc;
  logic       MemWrite, RegWrite;

  ctrl_t obs;
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .PCEnable(PCEnable),
    .InstructionRegisterEnable(InstructionRegisterEnable), .OLDPCEnable(OLDPCEnable),
    .InstructionOrData(InstructionOrData), .ImmediateSrc(ImmediateSrc),
    .REGAEnable(REGAEnable), .REGBEnable(REGBEnable), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControlSignal(ALUControlSignal), .ResultSrc(ResultSrc),
    .MemWrite(MemWrite), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  assign obs = {PCEnable, InstructionRegisterEnable, OLDPCEnable, InstructionOrData,
                ImmediateSrc, REGAEnable, REGBEnable, ALUSrcA, ALUSrcB,
                ALUControlSignal, ResultSrc, MemWrite, RegWrite};

  function automatic ctrl_t st_fetch();
    ctrl_t e = '0;
    e.pc = 1'b1; e.ir = 1'b1; e.oldpc = 1'b1; e.srcb = 2'd2; e.res = 2'd2;
    return e;
  endfunction

  function automatic ctrl_t st_decode(input logic br);
    ctrl_t e = '0;
    e.rega = 1'b1; e.regb = 1'b1;
    if (br) begin e.srca = 2'd1; e.srcb = 2'd1; e.imm = 3'd2; end
    return e;
  endfunction

  function automatic ctrl_t st_exec(input logic use_imm, input logic [3:0] alu);
    ctrl_t e = '0;
    e.srca = 2'd2; e.srcb = use_imm ? 2'd1 : 2'd0; e.alu = alu;
    return e;
  endfunction

  function automatic ctrl_t st_aluwb();
    ctrl_t e = '0;
    e.rw = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t st_mem(input logic [2:0] imm, input logic iod, input logic mw);
    ctrl_t e = '0;
    e.srca = 2'd2; e.srcb = 2'd1; e.imm = imm; e.iod = iod; e.mw = mw;
    return e;
  endfunction

  function automatic ctrl_t st_memwb();
    ctrl_t e = '0;
    e.res = 2'd1; e.rw = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t st_branch(input logic [3:0] alu, input logic taken);
    ctrl_t e = '0;
    e.srca = 2'd2; e.alu = alu; e.pc = taken;
    return e;
  endfunction

  function automatic ctrl_t st_jump(input logic jal);
    ctrl_t e = '0;
    e.srcb = 2'd1; e.res = 2'd2; e.pc = 1'b1;
    e.srca = jal ? 2'd1 : 2'd2; e.imm = jal ? 3'd4 : 3'd0;
    return e;
  endfunction

  function automatic ctrl_t st_link();
    ctrl_t e = '0;
    e.srca = 2'd1; e.srcb = 2'd2; e.res = 2'd2; e.rw = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t st_upper(input logic auipc);
    ctrl_t e = '0;
    e.imm = 3'd3; e.rw = 1'b1;
    if (auipc) begin e.srca = 2'd1; e.srcb = 2'd1; e.res = 2'd2; end
    else e.res = 2'd3;
    return e;
  endfunction

  task automatic push(input string tag, input ctrl_t v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  task automatic check_head();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
      end
      $display("check %-16s observed=%h expected=%h", x.tag, obs, x.v);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      check_head();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    Zero   = z;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    issue(7'b0, 3'b0, 7'b0, 1'b0);
    repeat (2) @(negedge clk);
    push("reset_hold", st_fetch()); check_head();
    reset = 1'b0;

    issue(7'b0110011, 3'b000, 7'b0100000, 1'b0);
    push("sub_fetch", st_fetch()); push("sub_decode", st_decode(1'b0));
    push("sub_exec", st_exec(1'b0, A_SUB)); push("sub_wb", st_aluwb()); drain();

    issue(7'b0110011, 3'b101, 7'b0100000, 1'b0);
    push("sra_fetch", st_fetch()); push("sra_decode", st_decode(1'b0));
    push("sra_exec", st_exec(1'b0, A_SRA)); push("sra_wb", st_aluwb()); drain();

    issue(7'b0110011, 3'b011, 7'b0000000, 1'b0);
    push("sltu_fetch", st_fetch()); push("sltu_decode", st_decode(1'b0));
    push("sltu_exec", st_exec(1'b0, A_SLTU)); push("sltu_wb", st_aluwb()); drain();

    issue(7'b0010011, 3'b000, 7'b0100000, 1'b0);
    push("addi_fetch", st_fetch()); push("addi_decode", st_decode(1'b0));
    push("addi_exec", st_exec(1'b1, A_ADD)); push("addi_wb", st_aluwb()); drain();

    issue(7'b0010011, 3'b101, 7'b0100000, 1'b0);
    push("srai_fetch", st_fetch()); push("srai_decode", st_decode(1'b0));
    push("srai_exec", st_exec(1'b1, A_SRA)); push("srai_wb", st_aluwb()); drain();

    issue(7'b0010011, 3'b101, 7'b0000000, 1'b0);
    push("srli_fetch", st_fetch()); push("srli_decode", st_decode(1'b0));
    push("srli_exec", st_exec(1'b1, A_SRL)); push("srli_wb", st_aluwb()); drain();

    issue(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    push("lw_fetch", st_fetch()); push("lw_decode", st_decode(1'b0));
    push("lw_memadr", st_mem(3'd0, 1'b0, 1'b0)); push("lw_memread", st_mem(3'd0, 1'b1, 1'b0));
    push("lw_memwb", st_memwb()); drain();

    issue(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    push("sw_fetch", st_fetch()); push("sw_decode", st_decode(1'b0));
    push("sw_memadr", st_mem(3'd1, 1'b0, 1'b0)); push("sw_memwrite", st_mem(3'd1, 1'b1, 1'b1));
    drain();

    issue(7'b1100011, 3'b001, 7'b0000000, 1'b0);
    push("bne_nz_fetch", st_fetch()); push("bne_nz_decode", st_decode(1'b1));
    push("bne_nz_branch", st_branch(A_SUB, 1'b1)); drain();

    issue(7'b1100011, 3'b001, 7'b0000000, 1'b1);
    push("bne_z_fetch", st_fetch()); push("bne_z_decode", st_decode(1'b1));
    push("bne_z_branch", st_branch(A_SUB, 1'b0)); drain();

    issue(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    push("beq_z_fetch", st_fetch()); push("beq_z_decode", st_decode(1'b1));
    push("beq_z_branch", st_branch(A_SUB, 1'b1)); drain();

    issue(7'b1100011, 3'b101, 7'b0000000, 1'b1);
    push("bge_z_fetch", st_fetch()); push("bge_z_decode", st_decode(1'b1));
    push("bge_z_branch", st_branch(A_SLT, 1'b1)); drain();

    issue(7'b1100011, 3'b110, 7'b0000000, 1'b0);
    push("bltu_fetch", st_fetch()); push("bltu_decode", st_decode(1'b1));
    push("bltu_branch", st_branch(A_SLTU, 1'b1)); drain();

    issue(7'b1100011, 3'b111, 7'b0000000, 1'b0);
    push("bgeu_fetch", st_fetch()); push("bgeu_decode", st_decode(1'b1));
    push("bgeu_branch", st_branch(A_SLTU, 1'b0)); drain();

    issue(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    push("jal_fetch", st_fetch()); push("jal_decode", st_decode(1'b0));
    push("jal_jump", st_jump(1'b1)); push("jal_link", st_link()); drain();

    issue(7'b1100111, 3'b000, 7'b0000000, 1'b0);
    push("jalr_fetch", st_fetch()); push("jalr_decode", st_decode(1'b0));
    push("jalr_jump", st_jump(1'b0)); push("jalr_link", st_link()); drain();

    issue(7'b0110111, 3'b000, 7'b0000000, 1'b0);
    push("lui_fetch", st_fetch()); push("lui_decode", st_decode(1'b0));
    push("lui_exec", st_upper(1'b0)); drain();

    issue(7'b0010111, 3'b000, 7'b0000000, 1'b0);
    push("auipc_fetch", st_fetch()); push("auipc_decode", st_decode(1'b0));
    push("auipc_exec", st_upper(1'b1)); drain();

    // Abandon a load in MEMREAD: FETCH must appear before any clock edge.
    issue(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    push("rst_fetch", st_fetch()); push("rst_decode", st_decode(1'b0));
    push("rst_memadr", st_mem(3'd0, 1'b0, 1'b0)); drain();
    push("rst_memread", st_mem(3'd0, 1'b1, 1'b0)); check_head();
    reset = 1'b1;
    #1;
    push("rst_async", st_fetch()); check_head();
    @(posedge clk);
    @(negedge clk);
    push("rst_held", st_fetch()); check_head();
    reset = 1'b0;

    issue(7'b0110111, 3'b000, 7'b0000000, 1'b0);
    push("post_rst_fetch", st_fetch()); push("post_rst_decode", st_decode(1'b0));
    push("post_rst_lui", st_upper(1'b0)); drain();

    issue(7'b0001111, 3'b000, 7'b0000000, 1'b0);
    push("ill_fetch", st_fetch()); push("ill_decode", st_decode(1'b0));
`ifdef CU_ILLEGAL_HALT_EN
    push("ill_halt0", ctrl_t'('0)); push("ill_halt1", ctrl_t'('0)); drain();
    reset = 1'b1;
    #1;
    push("halt_rst", st_fetch()); check_head();
    @(negedge clk);
    reset = 1'b0;
`else
    drain();
`endif

    issue(7'b0110011, 3'b111, 7'b0000000, 1'b0);
    push("final_fetch", st_fetch()); push("final_decode", st_decode(1'b0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
